// File: rtl/tl_pkg.sv
// Shared constants for the lane sensor front-end: lane indices, default sizing
// and the queue-update encoding used by each approach tracker.
package tl_pkg;

  localparam int LANE_XL   = 0;
  localparam int LANE_XR   = 1;
  localparam int LANE_YU   = 2;
  localparam int LANE_YD   = 3;
  localparam int NUM_LANES = 4;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_DEB_CYCLES = 3;
  localparam int DEF_JAM_THRESH = 8;
  localparam int DEF_JAM_HYST   = 2;

  // Bit order matches {arr_ev, dep_ev}
  typedef enum logic [1:0] {
    UPD_HOLD = 2'b00,
    UPD_DEP  = 2'b01,
    UPD_ARR  = 2'b10,
    UPD_BOTH = 2'b11
  } upd_e;

endpackage

// File: rtl/lane_queue_tracker.sv
// One approach: synchronise and debounce the entry and stop-line loops, count the queue.
// Jam flag hysteresis is enabled by defining TL_JAM_HYST_EN.
module lane_queue_tracker
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int JAM_THRESH = DEF_JAM_THRESH
`ifdef TL_JAM_HYST_EN
  ,
  parameter int JAM_HYST   = DEF_JAM_HYST
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arr_raw,
  input  logic             dep_raw,
  output logic             s1,
  output logic             s2,
  output logic [CNT_W-1:0] count,
  output logic             sat_err
);

  localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [DCW-1:0]   DEB_ZERO = {DCW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(JAM_THRESH);
`ifdef TL_JAM_HYST_EN
  localparam logic [CNT_W-1:0] LOW_V    = CNT_W'(JAM_THRESH - JAM_HYST);
`endif

  // Index 0 is the entry loop, index 1 the stop-line loop
  logic [1:0]     raw_s;
  logic [1:0]     meta_r;
  logic [1:0]     sync_r;
  logic [1:0]     deb_r;
  logic [1:0]     deb_d_r;
  logic [DCW-1:0] deb_cnt_r [2];
  logic           arr_ev_s;
  logic           dep_ev_s;
  logic [CNT_W-1:0] count_r;
  logic           sat_r;
  logic           s1_r;
  logic           s2_r;

  assign raw_s = {dep_raw, arr_raw};

  // Two-flop synchronisers, debounce counters and the delayed level for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r  <= 2'b00;
      sync_r  <= 2'b00;
      deb_r   <= 2'b00;
      deb_d_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
      end
    end else begin
      meta_r  <= raw_s;
      sync_r  <= meta_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_r[i]     <= sync_r[i];
            deb_cnt_r[i] <= DEB_ZERO;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DCW'(1);
          end
        end else begin
          deb_cnt_r[i] <= DEB_ZERO;
        end
      end
    end
  end

  assign arr_ev_s = deb_r[0] & ~deb_d_r[0];
  assign dep_ev_s = deb_r[1] & ~deb_d_r[1];

  // Saturating queue counter; a blocked step is latched in the sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CNT_ZERO;
      sat_r   <= 1'b0;
    end else begin
      case (upd_e'({arr_ev_s, dep_ev_s}))
        UPD_ARR: begin
          if (count_r == CNT_MAX) begin
            sat_r <= 1'b1;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        UPD_DEP: begin
          if (count_r == CNT_ZERO) begin
            sat_r <= 1'b1;
          end else begin
            count_r <= count_r - CNT_W'(1);
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Presence and jam flags follow the counter by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= (count_r != CNT_ZERO);
`ifdef TL_JAM_HYST_EN
      if (count_r >= THRESH_V) begin
        s2_r <= 1'b1;
      end else if (count_r < LOW_V) begin
        s2_r <= 1'b0;
      end else begin
        s2_r <= s2_r;
      end
`else
      s2_r <= (count_r >= THRESH_V);
`endif
    end
  end

  assign s1      = s1_r;
  assign s2      = s2_r;
  assign count   = count_r;
  assign sat_err = sat_r;

endmodule

// File: rtl/lane_sensor_frontend.sv
// Four-approach loop sensor front-end feeding the intersection controller.
// Define TL_JAM_HYST_EN to add hysteresis to the s2_* jam flags.
module lane_sensor_frontend
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int JAM_THRESH = DEF_JAM_THRESH
`ifdef TL_JAM_HYST_EN
  ,
  parameter int JAM_HYST   = DEF_JAM_HYST
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_LANES-1:0]       arr_raw,
  input  logic [NUM_LANES-1:0]       dep_raw,
  output logic                       s1_xL,
  output logic                       s1_xR,
  output logic                       s1_yU,
  output logic                       s1_yD,
  output logic                       s2_xL,
  output logic                       s2_xR,
  output logic                       s2_yU,
  output logic                       s2_yD,
  output logic [NUM_LANES*CNT_W-1:0] q_count,
  output logic [NUM_LANES-1:0]       sat_err
);

  logic [NUM_LANES-1:0] s1_s;
  logic [NUM_LANES-1:0] s2_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_queue_tracker #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .JAM_THRESH (JAM_THRESH)
`ifdef TL_JAM_HYST_EN
      ,
      .JAM_HYST   (JAM_HYST)
`endif
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .arr_raw (arr_raw[g]),
      .dep_raw (dep_raw[g]),
      .s1      (s1_s[g]),
      .s2      (s2_s[g]),
      .count   (q_count[g*CNT_W +: CNT_W]),
      .sat_err (sat_err[g])
    );
  end

  assign s1_xL = s1_s[LANE_XL];
  assign s1_xR = s1_s[LANE_XR];
  assign s1_yU = s1_s[LANE_YU];
  assign s1_yD = s1_s[LANE_YD];
  assign s2_xL = s2_s[LANE_XL];
  assign s2_xR = s2_s[LANE_XR];
  assign s2_yU = s2_s[LANE_YU];
  assign s2_yD = s2_s[LANE_YD];

endmodule

// File: tb/tb_lane_sensor_frontend.sv
// Scoreboard bench for lane_sensor_frontend: expected output snapshots are queued with
// each stimulus and a negedge monitor pops one whenever the DUT outputs change.
module tb_lane_sensor_frontend;
  import tl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  arr_raw = 4'h0;
  logic [3:0]  dep_raw = 4'h0;
  logic        s1_xL, s1_xR, s1_yU, s1_yD;
  logic        s2_xL, s2_xR, s2_yU, s2_yD;
  logic [15:0] q_count;
  logic [3:0]  sat_err;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];
  logic [27:0] last_pushed;
  logic [27:0] prev_snap;
  bit          mon_en = 1'b0;

  int exp_cnt [4];
  bit exp_s1  [4];
  bit exp_s2  [4];
  bit exp_sat [4];

  lane_sensor_frontend dut (
    .clk     (clk),
    .reset   (reset),
    .arr_raw (arr_raw),
    .dep_raw (dep_raw),
    .s1_xL   (s1_xL),
    .s1_xR   (s1_xR),
    .s1_yU   (s1_yU),
    .s1_yD   (s1_yD),
    .s2_xL   (s2_xL),
    .s2_xR   (s2_xR),
    .s2_yU   (s2_yU),
    .s2_yD   (s2_yD),
    .q_count (q_count),
    .sat_err (sat_err)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] dut_snap();
    return {sat_err, s2_yD, s2_yU, s2_xR, s2_xL, s1_yD, s1_yU, s1_xR, s1_xL, q_count};
  endfunction

  function automatic logic [27:0] model_snap();
    logic [27:0] s;
    for (int i = 0; i < 4; i++) begin
      s[24+i]     = exp_sat[i];
      s[20+i]     = exp_s2[i];
      s[16+i]     = exp_s1[i];
      s[i*4 +: 4] = 4'(exp_cnt[i]);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_if_new();
    logic [27:0] s;
    s = model_snap();
    if (s != last_pushed) begin
      exp_q.push_back(s);
      last_pushed = s;
    end
  endtask

  // Counter moves first, the registered flags follow one cycle later
  task automatic model_event(input int lane, input bit arr, input bit dep);
    if (arr && !dep) begin
      if (exp_cnt[lane] == 15) exp_sat[lane] = 1'b1;
      else exp_cnt[lane] = exp_cnt[lane] + 1;
    end else if (dep && !arr) begin
      if (exp_cnt[lane] == 0) exp_sat[lane] = 1'b1;
      else exp_cnt[lane] = exp_cnt[lane] - 1;
    end
    push_if_new();
    exp_s1[lane] = (exp_cnt[lane] != 0);
`ifdef TL_JAM_HYST_EN
    if (exp_cnt[lane] >= 8) exp_s2[lane] = 1'b1;
    else if (exp_cnt[lane] < 6) exp_s2[lane] = 1'b0;
`else
    exp_s2[lane] = (exp_cnt[lane] >= 8);
`endif
    push_if_new();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_cnt[i] = 0;
      exp_s1[i]  = 1'b0;
      exp_s2[i]  = 1'b0;
      exp_sat[i] = 1'b0;
    end
    push_if_new();
  endtask

  task automatic pulse(input logic [3:0] a, input logic [3:0] d, input int hi);
    @(posedge clk);
    #1;
    arr_raw = a;
    dep_raw = d;
    repeat (hi) @(posedge clk);
    #1;
    arr_raw = 4'h0;
    dep_raw = 4'h0;
    repeat (10) @(posedge clk);
  endtask

  // Monitor: every output change must match the next queued snapshot
  always @(negedge clk) begin
    logic [27:0] s;
    if (mon_en) begin
      s = dut_snap();
      if (s !== prev_snap) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_change actual=%0h required=%0h", s, prev_snap);
        end else begin
          check("scoreboard", {4'h0, s}, {4'h0, exp_q.pop_front()});
        end
        prev_snap = s;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      exp_cnt[i] = 0; exp_s1[i] = 1'b0; exp_s2[i] = 1'b0; exp_sat[i] = 1'b0;
    end
    last_pushed = 28'h0;

    // 1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {4'h0, dut_snap()}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_snap = dut_snap();
    mon_en = 1'b1;

    // 2 arrival latency on xL
    model_event(LANE_XL, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    arr_raw[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lat_cnt_before", {28'h0, q_count[3:0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_cnt_at_e5", {28'h0, q_count[3:0]}, 32'd1);
    check("lat_s1_at_e5", {31'h0, s1_xL}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_s1_at_e6", {31'h0, s1_xL}, 32'd1);
    check("other_lanes_idle", {20'h0, q_count[15:4]}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    arr_raw = 4'h0;
    repeat (10) @(posedge clk);
    model_event(LANE_XL, 1'b0, 1'b1);
    pulse(4'h0, 4'h1, 6);
    check("xl_departed", {28'h0, q_count[3:0]}, 32'd0);

    // 3 glitches are filtered
    pulse(4'h0, 4'h4, 2);
    check("yu_glitch_empty", {28'h0, q_count[11:8]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      model_event(LANE_YU, 1'b1, 1'b0);
      pulse(4'h4, 4'h0, 6);
    end
    pulse(4'h0, 4'h4, 2);
    check("yu_glitch_holds4", {28'h0, q_count[11:8]}, 32'd4);

    // 4 jam on yD
    for (int k = 0; k < 8; k++) begin
      model_event(LANE_YD, 1'b1, 1'b0);
      pulse(4'h8, 4'h0, 6);
    end
    check("yd_jam_set", {31'h0, s2_yD}, 32'd1);
    model_event(LANE_YD, 1'b0, 1'b1);
    pulse(4'h0, 4'h8, 6);
`ifdef TL_JAM_HYST_EN
    check("yd_jam_at7", {31'h0, s2_yD}, 32'd1);
`else
    check("yd_jam_at7", {31'h0, s2_yD}, 32'd0);
`endif
    for (int k = 0; k < 2; k++) begin
      model_event(LANE_YD, 1'b0, 1'b1);
      pulse(4'h0, 4'h8, 6);
    end
    check("yd_cnt5", {28'h0, q_count[15:12]}, 32'd5);
    check("yd_jam_at5", {31'h0, s2_yD}, 32'd0);

    // 5 saturation both ends
    for (int k = 0; k < 16; k++) begin
      model_event(LANE_XR, 1'b1, 1'b0);
      pulse(4'h2, 4'h0, 6);
    end
    check("xr_sat_cnt", {28'h0, q_count[7:4]}, 32'd15);
    check("xr_sat_err", {31'h0, sat_err[1]}, 32'd1);
    model_event(LANE_XL, 1'b0, 1'b1);
    pulse(4'h0, 4'h1, 6);
    check("xl_underflow_cnt", {28'h0, q_count[3:0]}, 32'd0);
    check("xl_underflow_err", {31'h0, sat_err[0]}, 32'd1);

    // 6 simultaneous arrival and departure, then reset mid-debounce
    for (int k = 0; k < 3; k++) begin
      model_event(LANE_XL, 1'b1, 1'b0);
      pulse(4'h1, 4'h0, 6);
    end
    pulse(4'h1, 4'h1, 6);
    check("xl_simultaneous", {28'h0, q_count[3:0]}, 32'd3);
    @(posedge clk);
    #1;
    arr_raw[0] = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1;
    arr_raw = 4'h0;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_cnt", {16'h0, q_count}, 32'd0);
    check("mid_reset_sat", {28'h0, sat_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("no_stray_event", {16'h0, q_count}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
